alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_arbiter_alu.sv | 31 +++
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   alu_op_e    : 4-bit ALUControl encodings understood by the shared ALU
//   arb_state_e : arbiter states (IDLE = no result held, RESP = result held)
//   NUM_REQ     : number of requesters sharing the ALU
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SLL  = 4'b1010,
        ALU_SRL  = 4'b1011,
        ALU_SRA  = 4'b1100
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_e;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU shared by both requesters.
//   src_a, src_b : operands (shift amount is src_b[4:0])
//   alu_control  : op code (alu_op_e); unknown codes give 0
//   result       : operation result, add/sub wrap modulo 2^32
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  alu_control,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_ADD:  result = src_a + src_b;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_SLT:  result = {31'd0, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: result = {31'd0, src_a < src_b};
            ALU_SLL:  result = src_a << src_b[4:0];
            ALU_SRL:  result = src_a >> src_b[4:0];
            ALU_SRA:  result = $unsigned($signed(src_a) >>> src_b[4:0]);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU.
//   clk, reset_n          : clock, async active-low reset
//   ReqValid / ReqReady   : per-requester operation handshake
//   SrcA0/SrcB0/ALUControl0, SrcA1/SrcB1/ALUControl1 : requester operands
//   RespValid / RespReady : per-requester result handshake (RespValid one-hot)
//   ALUResult, Zero       : registered result and zero flag of the granted op
//   state_dbg             : current arbiter state, for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready of the
// same bit are both 1. ReqReady is only ever raised in IDLE, for exactly one
// requester, and depends combinationally on ReqValid. RespValid is held on the
// owner bit until RespReady of that bit is seen; the other RespReady bit is
// ignored. A consumed response returns to IDLE, so no request is accepted in
// the same edge a response is taken.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int FAIR_RR = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] ReqValid,
    output logic [NUM_REQ-1:0] ReqReady,
    input  logic [31:0]        SrcA0,
    input  logic [31:0]        SrcB0,
    input  logic [3:0]         ALUControl0,
    input  logic [31:0]        SrcA1,
    input  logic [31:0]        SrcB1,
    input  logic [3:0]         ALUControl1,
    output logic [NUM_REQ-1:0] RespValid,
    input  logic [NUM_REQ-1:0] RespReady,
    output logic [31:0]        ALUResult,
    output logic               Zero,
    output arb_state_e         state_dbg
);

    arb_state_e         state;
    logic               owner;        // requester whose result is held
    logic               last_winner;  // requester granted most recently
    logic [NUM_REQ-1:0] grant;
    logic               sel;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic [3:0]         op_ctrl;
    logic [31:0]        alu_out;

    always_comb begin
        grant = '0;
        if (state == IDLE) begin
            case (ReqValid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11: begin
                    // Round-robin favours whoever did not win last time.
                    if (FAIR_RR != 0) grant = last_winner ? 2'b01 : 2'b10;
                    else              grant = 2'b01;
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel = grant[1];

    // Grant-selected operand mux feeding the single shared ALU; operands are
    // only registered as the finished result.
    assign op_a    = sel ? SrcA1 : SrcA0;
    assign op_b    = sel ? SrcB1 : SrcB0;
    assign op_ctrl = sel ? ALUControl1 : ALUControl0;

    alu_arbiter_alu ALU (
        .src_a       (op_a),
        .src_b       (op_b),
        .alu_control (op_ctrl),
        .result      (alu_out)
    );

    // Gating with reset_n keeps ReqReady low while reset is held, even though
    // the state is already IDLE and requesters may be asserting valid.
    assign ReqReady  = grant & {NUM_REQ{reset_n}};
    assign RespValid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_winner <= 1'b1;
            ALUResult   <= '0;
            Zero        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != '0) begin
                        ALUResult   <= alu_out;
                        Zero        <= (alu_out == 32'd0);
                        owner       <= sel;
                        last_winner <= sel;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (RespReady[owner]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one round-robin and one fixed-priority instance share
// the same stimulus; each is tracked by its own behavioural model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ReqValid;
    logic [1:0]  RespReady;
    logic [31:0] SrcA0, SrcB0, SrcA1, SrcB1;
    logic [3:0]  ALUControl0, ALUControl1;

    logic [1:0]  rr_ready, rr_valid, fp_ready, fp_valid;
    logic [31:0] rr_res, fp_res;
    logic        rr_zero, fp_zero;
    arb_state_e  rr_st, fp_st;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    alu_arbiter #(.FAIR_RR(1)) dut_rr (
        .clk(clk), .reset_n(reset_n), .ReqValid(ReqValid), .ReqReady(rr_ready),
        .SrcA0(SrcA0), .SrcB0(SrcB0), .ALUControl0(ALUControl0),
        .SrcA1(SrcA1), .SrcB1(SrcB1), .ALUControl1(ALUControl1),
        .RespValid(rr_valid), .RespReady(RespReady),
        .ALUResult(rr_res), .Zero(rr_zero), .state_dbg(rr_st)
    );

    alu_arbiter #(.FAIR_RR(0)) dut_fp (
        .clk(clk), .reset_n(reset_n), .ReqValid(ReqValid), .ReqReady(fp_ready),
        .SrcA0(SrcA0), .SrcB0(SrcB0), .ALUControl0(ALUControl0),
        .SrcA1(SrcA1), .SrcB1(SrcB1), .ALUControl1(ALUControl1),
        .RespValid(fp_valid), .RespReady(RespReady),
        .ALUResult(fp_res), .Zero(fp_zero), .state_dbg(fp_st)
    );

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models the round-robin instance, index 1 the fixed-priority one.
    logic        m_held  [2];
    logic        m_owner [2];
    logic        m_ptr   [2];
    logic [31:0] m_res   [2];

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        int unsigned sh;
        sh = b[4:0];
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd4:  return a ^ b;
            4'd6:  return a - b;
            4'd7:  return ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
            4'd8:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return a << sh;
            4'd11: return a >> sh;
            4'd12: return a[31] ? ~((~a) >> sh) : (a >> sh);
            default: return 32'd0;
        endcase
    endfunction

    // Which requester wins when model d sees request vector v.
    function automatic logic winner(input int d, input logic [1:0] v);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
        if (d == 0)     return ~m_ptr[0];
        return 1'b0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                m_held[d]  <= 1'b0;
                m_owner[d] <= 1'b0;
                m_ptr[d]   <= 1'b1;
                m_res[d]   <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_held[d]) begin
                    if (ReqValid != 2'b00) begin
                        m_held[d]  <= 1'b1;
                        m_owner[d] <= winner(d, ReqValid);
                        m_ptr[d]   <= winner(d, ReqValid);
                        m_res[d]   <= winner(d, ReqValid) ?
                                      alu_ref(SrcA1, SrcB1, ALUControl1) :
                                      alu_ref(SrcA0, SrcB0, ALUControl0);
                    end
                end else if (RespReady[m_owner[d]]) begin
                    m_held[d] <= 1'b0;
                end
            end
        end
    end

    task automatic check_dut(input int d, input logic [1:0] rdy, input logic [1:0] vld,
                             input logic [31:0] r, input logic z, input arb_state_e s);
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_vld;
        logic [31:0] exp_r;
        exp_rdy = (!reset_n || m_held[d] || ReqValid == 2'b00) ? 2'b00 :
                  (winner(d, ReqValid) ? 2'b10 : 2'b01);
        exp_vld = (reset_n && m_held[d]) ? (m_owner[d] ? 2'b10 : 2'b01) : 2'b00;
        chk($sformatf("d%0d ReqReady", d), {30'd0, rdy}, {30'd0, exp_rdy});
        chk($sformatf("d%0d RespValid", d), {30'd0, vld}, {30'd0, exp_vld});
        chk($sformatf("d%0d state", d), {31'd0, s == RESP}, {31'd0, reset_n && m_held[d]});
        if (!reset_n || m_held[d]) begin
            exp_r = reset_n ? m_res[d] : 32'd0;
            chk($sformatf("d%0d ALUResult", d), r, exp_r);
            chk($sformatf("d%0d Zero", d), {31'd0, z},
                {31'd0, reset_n && (m_res[d] == 32'd0)});
        end
    endtask

    // Compare process: every falling edge, both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check_dut(0, rr_ready, rr_valid, rr_res, rr_zero, rr_st);
            check_dut(1, fp_ready, fp_valid, fp_res, fp_zero, fp_st);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_ops();
        logic [3:0] ops [12];
        ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11, 4'd12, 4'd3, 4'd15};
        SrcA0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
        SrcB0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
        SrcA1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
        SrcB1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
        ALUControl0 = ops[$urandom_range(0, 11)];
        ALUControl1 = ops[$urandom_range(0, 11)];
    endtask

    // Single request from one requester with literal expectations; both
    // instances must be idle on entry and are idle again on exit.
    task automatic run_single(input bit req, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] c, input logic [31:0] exp_r,
                              input bit exp_z, input string name);
        logic [1:0] oh;
        oh = req ? 2'b10 : 2'b01;
        if (req) begin SrcA1 = a; SrcB1 = b; ALUControl1 = c; end
        else     begin SrcA0 = a; SrcB0 = b; ALUControl0 = c; end
        ReqValid  = oh;
        RespReady = 2'b00;
        @(negedge clk);
        chk({name, " rr grant"}, {30'd0, rr_ready}, {30'd0, oh});
        chk({name, " fp grant"}, {30'd0, fp_ready}, {30'd0, oh});
        tick();
        ReqValid  = 2'b00;
        RespReady = 2'b11;
        @(negedge clk);
        chk({name, " rr valid"}, {30'd0, rr_valid}, {30'd0, oh});
        chk({name, " rr result"}, rr_res, exp_r);
        chk({name, " rr zero"}, {31'd0, rr_zero}, {31'd0, exp_z});
        chk({name, " fp result"}, fp_res, exp_r);
        tick();
        RespReady = 2'b00;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n   = 1'b0;
        ReqValid  = 2'b11;
        RespReady = 2'b00;
        SrcA0 = '0; SrcB0 = '0; SrcA1 = '0; SrcB1 = '0;
        ALUControl0 = '0; ALUControl1 = '0;
        chk_en = 1'b1;

        // model pins
        chk("pin add", alu_ref(32'd5, 32'd7, 4'b0010), 32'd12);
        chk("pin sra", alu_ref(32'h80000000, 32'd4, 4'b1100), 32'hF8000000);
        chk("pin slt", alu_ref(32'hFFFFFFFF, 32'd1, 4'b0111), 32'd1);
        chk("pin bad op", alu_ref(32'h1234, 32'd5, 4'b0011), 32'd0);

        // reset state with requests pending
        repeat (2) @(negedge clk);
        chk("reset rr ready", {30'd0, rr_ready}, 32'd0);
        chk("reset rr valid", {30'd0, rr_valid}, 32'd0);
        chk("reset rr result", rr_res, 32'd0);
        chk("reset rr zero", {31'd0, rr_zero}, 32'd0);
        tick();
        reset_n  = 1'b1;
        ReqValid = 2'b00;
        tick();

        run_single(1'b0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, "add");

        // held response, non-owner RespReady ignored, new requests blocked
        SrcA1 = 32'd3; SrcB1 = 32'd3; ALUControl1 = 4'b0110;
        ReqValid = 2'b10;
        @(negedge clk);
        chk("hold grant", {30'd0, rr_ready}, 32'd2);
        tick();
        ReqValid  = 2'b11;
        RespReady = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold valid", {30'd0, rr_valid}, 32'd2);
            chk("hold result", rr_res, 32'd0);
            chk("hold zero", {31'd0, rr_zero}, 32'd1);
            chk("hold ready", {30'd0, rr_ready}, 32'd0);
            chk("hold fp valid", {30'd0, fp_valid}, 32'd2);
            tick();
        end
        RespReady = 2'b10;
        ReqValid  = 2'b00;
        tick();
        RespReady = 2'b00;

        run_single(1'b0, 32'h80000000, 32'd4, 4'b1100, 32'hF8000000, 1'b0, "sra");
        run_single(1'b0, 32'h00001234, 32'd5, 4'b0011, 32'd0, 1'b1, "bad op");
        run_single(1'b1, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'd0, 1'b1, "add wrap");
        run_single(1'b0, 32'hFFFFFFFF, 32'd1, 4'b1000, 32'd0, 1'b1, "sltu");
        run_single(1'b1, 32'hFFFFFFFF, 32'd1, 4'b0111, 32'd1, 1'b0, "slt");
        run_single(1'b1, 32'h00000001, 32'd31, 4'b1010, 32'h80000000, 1'b0, "sll");

        // back-to-back contention after reset
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        ReqValid  = 2'b11;
        RespReady = 2'b11;
        randomize_ops();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rr seq %0d", k), {30'd0, rr_ready},
                (k % 2 == 1) ? 32'd0 : ((k % 4 == 0) ? 32'd1 : 32'd2));
            chk($sformatf("fp seq %0d", k), {30'd0, fp_ready},
                (k % 2 == 1) ? 32'd0 : 32'd1);
            tick();
        end
        ReqValid  = 2'b00;
        RespReady = 2'b00;
        tick();

        // reset in the middle of a held response
        run_single(1'b0, 32'd1, 32'd2, 4'b0001, 32'd3, 1'b0, "or");
        SrcA0 = 32'd9; SrcB0 = 32'd9; ALUControl0 = 4'b0000;
        ReqValid = 2'b01;
        tick();
        ReqValid = 2'b11;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid reset rr valid", {30'd0, rr_valid}, 32'd0);
        chk("mid reset rr result", rr_res, 32'd0);
        chk("mid reset fp valid", {30'd0, fp_valid}, 32'd0);
        chk("mid reset fp result", fp_res, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post reset rr valid", {30'd0, rr_valid}, 32'd0);
        chk("post reset rr grant", {30'd0, rr_ready}, 32'd1);
        chk("post reset fp grant", {30'd0, fp_ready}, 32'd1);
        tick();
        RespReady = 2'b11;
        ReqValid  = 2'b00;
        tick();
        RespReady = 2'b00;

        // randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            ReqValid  = 2'($urandom_range(0, 3));
            RespReady = 2'($urandom_range(0, 3));
            randomize_ops();
            tick();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
